// File: rtl/asteroids_pkg.sv
// Shared types and helpers for the asteroids game slice: collision FSM states,
// BCD digit type and a popcount helper.
package asteroids_pkg;

    localparam int T_NUM_DEFAULT = 4;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        REPORT
    } coll_state_t;

    typedef logic [3:0] bcd_digit_t;

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + (v[i] ? 1 : 0);
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Combinational double-dabble: 7-bit binary (0..99) to two BCD digits.
module bin2bcd8
    import asteroids_pkg::*;
(
    input  logic [6:0] bin,
    output bcd_digit_t tens,
    output bcd_digit_t ones
);

    logic [14:0] sr;

    always_comb begin
        sr = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sr[10:7] >= 4'd5) sr[10:7] = sr[10:7] + 4'd3;
            if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
            sr = sr << 1;
        end
    end

    assign tens = sr[14:11];
    assign ones = sr[10:7];

endmodule

// File: rtl/collision_tracker.sv
// Frame-coherent collision detector: accumulates ship/torpedo overlaps per frame
// and emits registered one-cycle events after each frame_start. Optional
// statistics counters are built when COLLISION_STATS_EN is defined.
module collision_tracker
    import asteroids_pkg::*;
#(
    parameter int T_NUM          = T_NUM_DEFAULT,
    parameter int MIN_OVERLAP    = 4,
    parameter int GRACE_FRAMES   = 120,
    parameter int POINTS_PER_HIT = 10
) (
    input  logic             clk_25,
    input  logic             resetN,
    input  logic             frame_start,
    input  logic             game_over,
    input  logic             draw_ship,
    input  logic             draw_asteroid,
    input  logic [T_NUM-1:0] draw_torpedo,
    output logic             ship_hit,
    output logic [T_NUM-1:0] torpedo_hit,
    output logic             score_add,
    output logic [7:0]       score_sum,
    output logic             invulnerable,
    output logic [15:0]      ships_lost,
    output logic [15:0]      asteroids_killed
);

    if (T_NUM * POINTS_PER_HIT > 99) begin : g_points_check
        $error("collision_tracker: T_NUM*POINTS_PER_HIT exceeds two BCD digits");
    end

    coll_state_t      state;
    logic [7:0]       ovl_cnt;
    logic [T_NUM-1:0] torp_sticky;
    logic [7:0]       grace_cnt;
    logic [7:0]       grace_next;

    logic             ship_ovl;
    logic [T_NUM-1:0] torp_ovl;
    logic             capture;
    logic             ship_fire;
    logic [T_NUM-1:0] torp_fire;
    logic [6:0]       hit_pts;
    bcd_digit_t       pts_tens;
    bcd_digit_t       pts_ones;

    assign ship_ovl  = draw_ship & draw_asteroid & ~invulnerable;
    assign torp_ovl  = draw_torpedo & {T_NUM{draw_asteroid}};
    assign capture   = (state == ACCUM) & frame_start;
    assign ship_fire = (ovl_cnt >= 8'(MIN_OVERLAP)) & ~game_over & ~invulnerable;
    assign torp_fire = torp_sticky & {T_NUM{~game_over}};
    assign hit_pts   = 7'(popcount(32'(torp_fire)) * POINTS_PER_HIT);

    bin2bcd8 u_bin2bcd8 (
        .bin  (hit_pts),
        .tens (pts_tens),
        .ones (pts_ones)
    );

    // A fresh load after a reported ship hit wins over the per-frame decrement.
    always_comb begin
        grace_next = grace_cnt;
        if (ship_hit) begin
            grace_next = 8'(GRACE_FRAMES);
        end else if (frame_start && grace_cnt != 8'd0) begin
            grace_next = grace_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state        <= WAIT_FRAME;
            ovl_cnt      <= 8'd0;
            torp_sticky  <= '0;
            grace_cnt    <= 8'd0;
            invulnerable <= 1'b0;
            ship_hit     <= 1'b0;
            torpedo_hit  <= '0;
            score_add    <= 1'b0;
            score_sum    <= 8'd0;
        end else begin
            case (state)
                WAIT_FRAME: if (frame_start) state <= ACCUM;
                ACCUM:      if (frame_start) state <= REPORT;
                REPORT:     state <= ACCUM;
                default:    state <= WAIT_FRAME;
            endcase

            // The overlap seen on the boundary cycle opens the new frame's tally.
            if (state == WAIT_FRAME && !frame_start) begin
                ovl_cnt     <= 8'd0;
                torp_sticky <= '0;
            end else if (capture || state == WAIT_FRAME) begin
                ovl_cnt     <= {7'd0, ship_ovl};
                torp_sticky <= torp_ovl;
            end else begin
                if (ship_ovl && ovl_cnt != 8'hFF) ovl_cnt <= ovl_cnt + 8'd1;
                torp_sticky <= torp_sticky | torp_ovl;
            end

            ship_hit    <= capture & ship_fire;
            torpedo_hit <= capture ? torp_fire : '0;
            score_add   <= capture & (|torp_fire);
            score_sum   <= (capture && (|torp_fire)) ? {pts_tens, pts_ones} : 8'd0;

            grace_cnt    <= grace_next;
            invulnerable <= (grace_next != 8'd0);
        end
    end

`ifdef COLLISION_STATS_EN
    logic [16:0] killed_sum;

    assign killed_sum = {1'b0, asteroids_killed} + 17'(popcount(32'(torpedo_hit)));

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            ships_lost       <= 16'd0;
            asteroids_killed <= 16'd0;
        end else begin
            if (ship_hit && ships_lost != 16'hFFFF) ships_lost <= ships_lost + 16'd1;
            if (state == REPORT) begin
                asteroids_killed <= killed_sum[16] ? 16'hFFFF : killed_sum[15:0];
            end
        end
    end
`else
    assign ships_lost       = 16'd0;
    assign asteroids_killed = 16'd0;
`endif

endmodule

// File: tb/tb_collision_tracker.sv
// Scoreboard bench for collision_tracker: frame-level reference model pushes
// expected boundary reports; a negedge monitor pops and compares them.
module tb_collision_tracker;

    localparam int T     = 4;
    localparam int MINO  = 4;
    localparam int GRACE = 2;
    localparam int PTS   = 10;

    logic         clk_25 = 1'b0;
    logic         resetN = 1'b0;
    logic         frame_start = 1'b0;
    logic         game_over = 1'b0;
    logic         draw_ship = 1'b0;
    logic         draw_asteroid = 1'b0;
    logic [T-1:0] draw_torpedo = '0;
    logic         ship_hit;
    logic [T-1:0] torpedo_hit;
    logic         score_add;
    logic [7:0]   score_sum;
    logic         invulnerable;
    logic [15:0]  ships_lost;
    logic [15:0]  asteroids_killed;

    collision_tracker #(
        .T_NUM          (T),
        .MIN_OVERLAP    (MINO),
        .GRACE_FRAMES   (GRACE),
        .POINTS_PER_HIT (PTS)
    ) dut (
        .clk_25           (clk_25),
        .resetN           (resetN),
        .frame_start      (frame_start),
        .game_over        (game_over),
        .draw_ship        (draw_ship),
        .draw_asteroid    (draw_asteroid),
        .draw_torpedo     (draw_torpedo),
        .ship_hit         (ship_hit),
        .torpedo_hit      (torpedo_hit),
        .score_add        (score_add),
        .score_sum        (score_sum),
        .invulnerable     (invulnerable),
        .ships_lost       (ships_lost),
        .asteroids_killed (asteroids_killed)
    );

    always #20 clk_25 = ~clk_25;

    int cyc = 0;
    always @(posedge clk_25) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int           cyc;
        logic         ship;
        logic [T-1:0] torp;
        logic         sadd;
        logic [7:0]   ssum;
        logic         inv;
    } exp_t;

    exp_t q[$];

    // Frame-level reference state
    bit           m_run;
    int           m_ovl;
    logic [T-1:0] m_torp;
    int           m_grace;
    int           m_lost;
    int           m_killed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_ovl = 0; m_torp = '0; m_grace = 0; m_lost = 0; m_killed = 0;
        q.delete();
    endtask

    task automatic model_step(input logic fs, input logic sp, input logic [T-1:0] tp, input logic go);
        int           dec;
        int           n;
        bit           hit;
        logic [T-1:0] tm;
        exp_t         e;
        if (fs) begin
            dec = (m_grace > 0) ? m_grace - 1 : 0;
            hit = 0;
            if (m_run) begin
                hit = (m_ovl >= MINO) && !go && (m_grace == 0);
                tm  = go ? '0 : m_torp;
                n   = $countones(tm) * PTS;
                e.cyc  = cyc + 1;
                e.ship = hit;
                e.torp = tm;
                e.sadd = (tm != '0);
                e.ssum = {4'(n / 10), 4'(n % 10)};
                e.inv  = (dec != 0);
                q.push_back(e);
                if (hit && m_lost < 65535) m_lost++;
                m_killed = (m_killed + $countones(tm) > 65535) ? 65535 : m_killed + $countones(tm);
            end
            m_ovl   = (sp && m_grace == 0) ? 1 : 0;
            m_torp  = tp;
            m_run   = 1;
            m_grace = hit ? GRACE : dec;
        end else if (m_run) begin
            if (sp && m_grace == 0 && m_ovl < 255) m_ovl++;
            m_torp = m_torp | tp;
        end
    endtask

    task automatic tick(input logic fs, input logic ship, input logic ast,
                        input logic [T-1:0] tp, input logic go);
        frame_start   = fs;
        draw_ship     = ship;
        draw_asteroid = ast;
        draw_torpedo  = tp;
        game_over     = go;
        model_step(fs, ship & ast, tp & {T{ast}}, go);
        @(posedge clk_25);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef COLLISION_STATS_EN
        chk({tag, "_ships_lost"}, 32'(ships_lost), 32'(m_lost));
        chk({tag, "_asteroids_killed"}, 32'(asteroids_killed), 32'(m_killed));
`else
        chk({tag, "_ships_lost"}, 32'(ships_lost), 32'd0);
        chk({tag, "_asteroids_killed"}, 32'(asteroids_killed), 32'd0);
`endif
    endtask

    task automatic do_frame(input int nship, input logic [T-1:0] tmask, input logic go,
                            input logic fs_ship, input logic [T-1:0] fs_torp);
        logic [T-1:0] tp;
        logic         ship;
        logic         ast;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, '0, go);
        chk("invulnerable", 32'(invulnerable), 32'(m_grace != 0));
        chk_stats("frame");
        for (int i = 0; i < 32; i++) begin
            ship = 1'b0; ast = 1'b0; tp = '0;
            if (i < nship) begin
                ship = 1'b1; ast = 1'b1;
            end else if (i >= 20 && i < 20 + T) begin
                tp[i-20] = 1'b1;
                ast = tmask[i-20];
            end else if (i == 30) begin
                ship = 1'b1;
            end
            tick(1'b0, ship, ast, tp, go);
        end
        tick(1'b1, fs_ship, fs_ship | (fs_torp != '0), fs_torp, go);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ship_hit"}, 32'(ship_hit), 32'd0);
        chk({tag, "_torpedo_hit"}, 32'(torpedo_hit), 32'd0);
        chk({tag, "_score_add"}, 32'(score_add), 32'd0);
        chk({tag, "_score_sum"}, 32'(score_sum), 32'd0);
        chk({tag, "_invulnerable"}, 32'(invulnerable), 32'd0);
        chk({tag, "_ships_lost"}, 32'(ships_lost), 32'd0);
        chk({tag, "_asteroids_killed"}, 32'(asteroids_killed), 32'd0);
    endtask

    task automatic mid_frame_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, '0, 1'b0);
        resetN = 1'b0;
        #2;
        chk_all_zero("reset_mid");
        model_reset();
        @(posedge clk_25);
        #1;
        resetN = 1'b1;
        @(posedge clk_25);
        #1;
    endtask

    // Monitor: compares each boundary report when due, and flags stray events otherwise
    exp_t me;
    always @(negedge clk_25) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL report_missed: due cycle %0d not seen, now %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            me = q.pop_front();
            chk("ship_hit", 32'(ship_hit), 32'(me.ship));
            chk("torpedo_hit", 32'(torpedo_hit), 32'(me.torp));
            chk("score_add", 32'(score_add), 32'(me.sadd));
            chk("score_sum", 32'(score_sum), 32'(me.ssum));
            chk("report_invulnerable", 32'(invulnerable), 32'(me.inv));
        end else begin
            chk("idle_events", 32'({ship_hit, score_add, torpedo_hit, score_sum}), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_25);
        #1;
        chk_all_zero("reset");
        resetN = 1'b1;
        @(posedge clk_25);
        #1;

        do_frame(3, '0, 1'b0, 1'b0, '0);        // first partial frame: discarded
        do_frame(4, '0, 1'b0, 1'b0, '0);        // exactly MIN_OVERLAP: ship hit
        do_frame(10, '0, 1'b0, 1'b0, '0);       // invulnerable
        do_frame(10, '0, 1'b0, 1'b0, '0);       // invulnerable, grace expires
        do_frame(10, '0, 1'b0, 1'b0, '0);       // ship hit again
        do_frame(0, 4'b0101, 1'b0, 1'b0, '0);   // two torpedoes: 8'h20
        do_frame(0, '0, 1'b0, 1'b0, '0);        // empty frame
        do_frame(0, '0, 1'b0, 1'b0, 4'b0010);   // overlap on the boundary cycle
        do_frame(0, '0, 1'b0, 1'b0, '0);        // ...reported here
        do_frame(8, 4'b1111, 1'b1, 1'b0, '0);   // game over suppresses
        do_frame(8, 4'b1111, 1'b1, 1'b0, '0);
        do_frame(0, '0, 1'b0, 1'b0, '0);        // clean frame, no stale events

        for (int f = 0; f < 30; f++) begin
            do_frame($urandom_range(0, 8), T'($urandom), ($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 1)), T'($urandom));
        end

        mid_frame_reset();
        do_frame(0, '0, 1'b0, 1'b0, '0);
        do_frame(4, 4'b0101, 1'b0, 1'b0, '0);
        do_frame(0, '0, 1'b0, 1'b0, '0);
        do_frame(0, '0, 1'b0, 1'b0, '0);
        do_frame(4, 4'b0111, 1'b0, 1'b0, '0);
        do_frame(0, '0, 1'b0, 1'b0, '0);
        do_frame(0, '0, 1'b0, 1'b0, '0);
        do_frame(4, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef COLLISION_STATS_EN
        chk("stats_ships_lost_3", 32'(ships_lost), 32'd3);
        chk("stats_asteroids_killed_5", 32'(asteroids_killed), 32'd5);
`else
        chk("stats_ships_lost_off", 32'(ships_lost), 32'd0);
        chk("stats_asteroids_killed_off", 32'(asteroids_killed), 32'd0);
`endif
        mid_frame_reset();

        do_frame(5, 4'b1111, 1'b0, 1'b0, '0);   // discarded after reset
        do_frame(0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
